// File: rtl/ofdm_qpsk_demapper.sv
// ofdm_qpsk_demapper
//   Receive-side QPSK hard-decision demapper for one OFDM symbol of N_BINS
//   frequency bins. Each accepted bin yields {im_bit, re_bit}; four bins are
//   packed LSB-pair-first into a byte, which is pushed into an output FIFO.
//   Symbol completion, low-confidence symbols and framing errors are flagged.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_bin_re/i_bin_im       signed bin components, WORD_SIZE bits
//   i_bin_valid/i_bin_last  bin handshake and end-of-symbol marker
//   o_bin_ready             high unless the byte FIFO is full
//   o_byte/o_byte_valid     FIFO head (first-word-fall-through), non-empty
//   i_byte_ready            downstream pop
//   o_symbol_done           1-cycle pulse after bin N_BINS-1 is accepted
//   o_symbol_lowconf        qualifies o_symbol_done: some bin under THRESH
//   o_frame_err             1-cycle pulse on i_bin_last / index mismatch
module ofdm_qpsk_demapper #(
    parameter int WORD_SIZE   = 16,
    parameter int DATA_LENGTH = 8,
    parameter int N_BINS      = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int THRESH      = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [WORD_SIZE-1:0]   i_bin_re,
    input  logic [WORD_SIZE-1:0]   i_bin_im,
    input  logic                   i_bin_valid,
    input  logic                   i_bin_last,
    output logic                   o_bin_ready,
    output logic [DATA_LENGTH-1:0] o_byte,
    output logic                   o_byte_valid,
    input  logic                   i_byte_ready,
    output logic                   o_symbol_done,
    output logic                   o_symbol_lowconf,
    output logic                   o_frame_err
);
    localparam int IW = $clog2(N_BINS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [IW-1:0]    LAST_IDX = IW'(N_BINS - 1);
    localparam logic [PW:0]      FULL     = (PW+1)'(FIFO_DEPTH);
    localparam logic [WORD_SIZE:0] THR    = (WORD_SIZE+1)'(THRESH);

    logic [IW-1:0]          bin_idx;
    logic [5:0]             part;      // pairs of bins j=0..2 of the byte in progress
    logic                   lc_acc;
    logic [DATA_LENGTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [PW:0]            count;

    logic                   accept, at_end, byte_wr, fifo_rd;
    logic                   re_bit, im_bit, bin_lc;
    logic [WORD_SIZE:0]     re_ext, im_ext, re_mag, im_mag;
    logic [DATA_LENGTH-1:0] new_byte;

    assign o_bin_ready  = (count != FULL);
    assign o_byte_valid = (count != '0);
    assign o_byte       = o_byte_valid ? mem[rd_ptr] : '0;

    assign accept  = i_bin_valid & o_bin_ready;
    assign fifo_rd = i_byte_ready & o_byte_valid;
    assign at_end  = (bin_idx == LAST_IDX);
    // bin 4n+3 closes a byte, even when it also carries an early last
    assign byte_wr = accept & (bin_idx[1:0] == 2'd3);

    assign re_bit   = ~i_bin_re[WORD_SIZE-1];
    assign im_bit   = ~i_bin_im[WORD_SIZE-1];
    assign new_byte = {im_bit, re_bit, part};

    // one extra bit so that |-2^(WORD_SIZE-1)| is representable
    assign re_ext = {i_bin_re[WORD_SIZE-1], i_bin_re};
    assign im_ext = {i_bin_im[WORD_SIZE-1], i_bin_im};
    assign re_mag = re_ext[WORD_SIZE] ? -re_ext : re_ext;
    assign im_mag = im_ext[WORD_SIZE] ? -im_ext : im_ext;
    assign bin_lc = (re_mag < THR) | (im_mag < THR);

    // symbol framing, packing and status pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bin_idx          <= '0;
            part             <= '0;
            lc_acc           <= 1'b0;
            o_symbol_done    <= 1'b0;
            o_symbol_lowconf <= 1'b0;
            o_frame_err      <= 1'b0;
        end else begin
            o_symbol_done    <= 1'b0;
            o_symbol_lowconf <= 1'b0;
            o_frame_err      <= 1'b0;
            if (accept) begin
                if (at_end) begin
                    // missing last still completes the symbol
                    o_symbol_done    <= 1'b1;
                    o_symbol_lowconf <= lc_acc | bin_lc;
                    o_frame_err      <= ~i_bin_last;
                    bin_idx          <= '0;
                    lc_acc           <= 1'b0;
                end else if (i_bin_last) begin
                    // early last: drop the partial byte and restart the symbol
                    o_frame_err <= 1'b1;
                    bin_idx     <= '0;
                    lc_acc      <= 1'b0;
                    part        <= '0;
                end else begin
                    bin_idx <= bin_idx + 1'b1;
                    lc_acc  <= lc_acc | bin_lc;
                    case (bin_idx[1:0])
                        2'd0:    part[1:0] <= {im_bit, re_bit};
                        2'd1:    part[3:2] <= {im_bit, re_bit};
                        2'd2:    part[5:4] <= {im_bit, re_bit};
                        default: ;
                    endcase
                end
            end
        end
    end

    // byte FIFO storage (no reset needed: o_byte is masked while empty)
    always_ff @(posedge i_clk) begin
        if (byte_wr) mem[wr_ptr] <= new_byte;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (byte_wr) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({byte_wr, fifo_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ofdm_qpsk_demapper.sv
module tb_ofdm_qpsk_demapper;
    localparam int FD = 16;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic [15:0]       i_bin_re = '0, i_bin_im = '0;
    logic              i_bin_valid = 1'b0, i_bin_last = 1'b0, i_byte_ready = 1'b0;
    logic              o_bin_ready, o_byte_valid, o_symbol_done, o_symbol_lowconf, o_frame_err;
    logic [7:0]        o_byte;

    ofdm_qpsk_demapper dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_bin_re(i_bin_re), .i_bin_im(i_bin_im),
        .i_bin_valid(i_bin_valid), .i_bin_last(i_bin_last),
        .o_bin_ready(o_bin_ready),
        .o_byte(o_byte), .o_byte_valid(o_byte_valid), .i_byte_ready(i_byte_ready),
        .o_symbol_done(o_symbol_done), .o_symbol_lowconf(o_symbol_lowconf),
        .o_frame_err(o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] mq[$];
    int  m_idx = 0, m_pairs = 0, m_byte = 0;
    bit  m_lc = 0, e_done = 0, e_lc = 0, e_ferr = 0;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mq.delete();
            m_idx = 0; m_pairs = 0; m_byte = 0; m_lc = 0;
            e_done = 0; e_lc = 0; e_ferr = 0;
        end else begin
            bit acc, rd, lcb;
            int re, im;
            acc = i_bin_valid && (mq.size() < FD);
            rd  = i_byte_ready && (mq.size() > 0);
            e_done = 0; e_lc = 0; e_ferr = 0;
            if (rd) void'(mq.pop_front());
            if (acc) begin
                re = int'($signed(i_bin_re));
                im = int'($signed(i_bin_im));
                lcb = (iabs(re) < 32) || (iabs(im) < 32);
                m_byte = m_byte + (((im >= 0) ? 2 : 0) + ((re >= 0) ? 1 : 0)) * (4 ** m_pairs);
                m_pairs++;
                if (m_pairs == 4) begin
                    mq.push_back(8'(m_byte));
                    m_pairs = 0; m_byte = 0;
                end
                m_lc = m_lc | lcb;
                if (m_idx == 31) begin
                    e_done = 1; e_lc = m_lc; e_ferr = !i_bin_last;
                    m_idx = 0; m_lc = 0;
                end else if (i_bin_last) begin
                    e_ferr = 1; m_idx = 0; m_lc = 0; m_pairs = 0; m_byte = 0;
                end else begin
                    m_idx++;
                end
            end
        end
    end

    // ---------------- per-cycle compare + observation log ----------------
    logic [7:0] got[$];
    int done_cnt = 0, lc_cnt = 0, ferr_cnt = 0, both_cnt = 0;

    always @(negedge i_clk) begin
        chk("bin_ready",  int'(o_bin_ready),      int'(mq.size() != FD));
        chk("byte_valid", int'(o_byte_valid),     int'(mq.size() != 0));
        chk("byte",       int'(o_byte),           (mq.size() != 0) ? int'(mq[0]) : 0);
        chk("sym_done",   int'(o_symbol_done),    int'(e_done));
        chk("sym_lowconf",int'(o_symbol_lowconf), int'(e_lc));
        chk("frame_err",  int'(o_frame_err),      int'(e_ferr));
        if (o_byte_valid && i_byte_ready) got.push_back(o_byte);
        if (o_symbol_done) done_cnt++;
        if (o_symbol_done && o_symbol_lowconf) lc_cnt++;
        if (o_frame_err) ferr_cnt++;
        if (o_frame_err && o_symbol_done) both_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    int acc_cnt = 0;
    int gb, db, lb, fb, bb;

    task automatic send_bin(input int re, input int im, input bit last);
        int n = 0;
        bit r = 0;
        i_bin_re = 16'(re); i_bin_im = 16'(im); i_bin_last = last; i_bin_valid = 1'b1;
        do begin
            @(negedge i_clk); r = o_bin_ready;
            @(posedge i_clk); #1; n++;
        end while (!r && n < 1000);
        if (!r) chk("bin_accept_timeout", 0, 1);
        else acc_cnt++;
        i_bin_valid = 1'b0; i_bin_last = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last);
        for (int j = 0; j < 4; j++)
            send_bin(b[2*j] ? 256 : -256, b[2*j+1] ? 256 : -256, last && j == 3);
    endtask

    // symbol of 8'hC4 bytes with overrides on bins 16/17
    task automatic send_sym_c4(input int r16, input int i16, input int r17);
        logic [7:0] b;
        int re, im;
        b = 8'hC4;
        for (int k = 0; k < 32; k++) begin
            re = b[2*(k%4)]   ? 256 : -256;
            im = b[2*(k%4)+1] ? 256 : -256;
            if (k == 16) begin re = r16; im = i16; end
            if (k == 17) re = r17;
            send_bin(re, im, k == 31);
        end
    endtask

    task automatic mark();
        gb = got.size(); db = done_cnt; lb = lc_cnt; fb = ferr_cnt; bb = both_cnt;
    endtask

    task automatic drain();
        int n = 0;
        i_byte_ready = 1'b1;
        while (o_byte_valid && n < 100) begin @(posedge i_clk); #1; n++; end
        if (n >= 100) chk("drain_timeout", 0, 1);
        repeat (3) @(posedge i_clk);
        #1;
    endtask

    task automatic check_got(input string name, input logic [7:0] e[$]);
        chk({name, "_count"}, got.size() - gb, e.size());
        for (int i = 0; i < e.size() && gb + i < got.size(); i++)
            chk(name, int'(got[gb+i]), int'(e[i]));
    endtask

    task automatic check_flags(input string name, input int d, input int l, input int f, input int bo);
        chk({name, "_done"},    done_cnt - db, d);
        chk({name, "_lowconf"}, lc_cnt - lb,   l);
        chk({name, "_ferr"},    ferr_cnt - fb, f);
        chk({name, "_both"},    both_cnt - bb, bo);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e[$];
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_ready", int'(o_bin_ready), 1);
        chk("rst_valid", int'(o_byte_valid), 0);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // mapping: 8 x C4
        mark(); i_byte_ready = 1'b1;
        send_sym_c4(-256, -256, 256);
        drain();
        e.delete(); for (int i = 0; i < 8; i++) e.push_back(8'hC4);
        check_got("map", e);
        check_flags("map", 1, 0, 0, 0);

        // backpressure: 3 symbols of bytes 0x00..0x17 with reader stalled
        mark(); i_byte_ready = 1'b0; acc_cnt = 0;
        fork
            for (int k = 0; k < 24; k++) send_byte(8'(k), (k % 8) == 7);
            begin
                repeat (90) @(posedge i_clk);
                #1;
                chk("stall_bins",  acc_cnt, 64);
                chk("stall_ready", int'(o_bin_ready), 0);
                chk("stall_valid", int'(o_byte_valid), 1);
                i_byte_ready = 1'b1;
            end
        join
        drain();
        e.delete(); for (int i = 0; i < 24; i++) e.push_back(8'(i));
        check_got("bp", e);
        check_flags("bp", 3, 0, 0, 0);

        // low confidence: bin 17 re=+31, then re=+32 with -32768 on bin 16
        mark();
        send_sym_c4(-256, -256, 31);
        send_sym_c4(-32768, -32768, 32);
        drain();
        e.delete(); for (int i = 0; i < 16; i++) e.push_back(8'hC4);
        check_got("lc", e);
        check_flags("lc", 2, 1, 0, 0);

        // early last at bin 9
        mark();
        send_byte(8'h1B, 0);
        send_byte(8'h2D, 0);
        send_bin(256, 256, 0);
        send_bin(-256, 256, 1);
        for (int k = 0; k < 8; k++) send_byte(8'h30 + 8'(k), k == 7);
        drain();
        e.delete(); e.push_back(8'h1B); e.push_back(8'h2D);
        for (int k = 0; k < 8; k++) e.push_back(8'h30 + 8'(k));
        check_got("early", e);
        check_flags("early", 1, 0, 1, 0);

        // missing last, then a normal symbol
        mark();
        for (int k = 0; k < 8; k++) send_byte(8'h40 + 8'(k), 0);
        for (int k = 0; k < 8; k++) send_byte(8'h50 + 8'(k), k == 7);
        drain();
        e.delete();
        for (int k = 0; k < 8; k++) e.push_back(8'h40 + 8'(k));
        for (int k = 0; k < 8; k++) e.push_back(8'h50 + 8'(k));
        check_got("miss", e);
        check_flags("miss", 2, 0, 1, 1);

        // reset mid-byte with buffered data
        i_byte_ready = 1'b0;
        send_byte(8'hAA, 0);
        send_bin(256, 256, 0);
        send_bin(256, 256, 0);
        chk("pre_rst_valid", int'(o_byte_valid), 1);
        chk("pre_rst_byte",  int'(o_byte), 'hAA);
        i_rst_n = 1'b0;
        #1;
        chk("arst_valid",   int'(o_byte_valid), 0);
        chk("arst_byte",    int'(o_byte), 0);
        chk("arst_ready",   int'(o_bin_ready), 1);
        chk("arst_done",    int'(o_symbol_done), 0);
        chk("arst_lowconf", int'(o_symbol_lowconf), 0);
        chk("arst_ferr",    int'(o_frame_err), 0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        chk("post_rst_ready", int'(o_bin_ready), 1);
        chk("post_rst_valid", int'(o_byte_valid), 0);
        mark(); i_byte_ready = 1'b1;
        for (int k = 0; k < 8; k++) send_byte(8'h60 + 8'(k), k == 7);
        drain();
        e.delete(); for (int k = 0; k < 8; k++) e.push_back(8'h60 + 8'(k));
        check_got("post_rst", e);
        check_flags("post_rst", 1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
